perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
// - Parametrised per-port cache performance monitor. Counts transactions, hits, misses and
//   stall cycles on NUM_CH access/resp channels (e.g. I-cache, D-cache, L2, arbiter).
// - Monitor only: never drives the memory path. Counters are read over a registered select port.
// - Successor to the single-purpose cache statistics block. Adds per-transaction (not per-cycle)
//   hit/miss classification, stall accounting, saturation, synchronous clear, enable, readout.
// PARAMETERS
// - NUM_CH   4    number of monitored access/resp channels (>=1)
// - CNT_W    32   width of every counter (>=2)
// - CH_IDX_W $clog2(NUM_CH) (min 1) width of rd_ch; derived, do not override
// PORTS
// - clk      in   1         system clock, all logic on posedge
// - rst      in   1         synchronous, active-high reset
// - en       in   1         count enable; 0 = counters hold, channel FSMs keep tracking
// - clr      in   1         synchronous clear of all counters and sat_flag
// - access   in   NUM_CH    per-channel request; held high until resp
// - resp     in   NUM_CH    per-channel response; 1-cycle pulse completing the request
// - rd_en    in   1         readout strobe
// - rd_ch    in   CH_IDX_W  channel to read
// - rd_sel   in   2         counter to read: 0 ACC, 1 HIT, 2 MISS, 3 STALL
// - rd_data  out  CNT_W     registered readout value
// - rd_valid out  1         high 1 cycle after rd_en
// - sat_flag out  NUM_CH    sticky: some counter of the channel has saturated
// BEHAVIOUR
// - Reset: every counter 0, all FSMs IDLE, rd_data 0, rd_valid 0, sat_flag 0.
// - Per-channel FSM with two states: IDLE and WAIT.
//   - IDLE, access&resp: hit. ACC+1, HIT+1. Stay in IDLE.
//   - IDLE, access&!resp: miss. ACC+1, MISS+1, STALL+1. Go to WAIT.
//   - WAIT, access&!resp: STALL+1. Stay in WAIT.
//   - WAIT, resp: complete. No increment. Go to IDLE.
//   - WAIT, !access&!resp: abort. Go to IDLE. Counts are kept.
//   - resp without access: ignored.
//   - access high in the cycle after a resp: new transaction, evaluated from IDLE.
// - STALL counts exactly the cycles with access=1 and resp=0.
// - en=0: no increments, but FSM transitions still occur.
//   - Re-enabling mid-transaction adds no spurious miss.
// - clr=1: all counters and sat_flag go to 0 next cycle. FSM state is kept.
//   - clr together with an increment: clr wins, value is 0.
// - Saturation: a counter at 2^CNT_W-1 holds there, it never wraps.
//   - On the cycle a counter reaches max, that channel's sat_flag sets.
//   - sat_flag stays set until clr or rst.
// - Readout:
//   - rd_en in cycle N gives rd_data and rd_valid=1 in cycle N+1.
//   - rd_data holds its value when rd_en=0.
//   - Same-cycle increment: the read returns the pre-increment value.
//   - rd_ch >= NUM_CH returns 0, with rd_valid still asserted.
// - rst wins over clr, en and rd_en. Reset during WAIT returns the FSM to IDLE, with no count.
// STRUCTURE
// - Package perf_pkg:
//   - typedef enum logic [1:0] {SEL_ACC, SEL_HIT, SEL_MISS, SEL_STALL} perf_sel_t
//   - typedef enum logic {CH_IDLE, CH_WAIT} perf_ch_state_t
// - Sub-module perf_channel (parameter CNT_W): holds one FSM, 4 saturating counters and a
//   sat bit, and exposes all 4 counts.
// - Top: generate loop of NUM_CH perf_channel instances, plus the registered readout mux.
// TESTING (NUM_CH=2, CNT_W=8)
// - Hit: ch0 access&resp for 1 cycle, x3.
//   -> ch0 ACC=3, HIT=3, MISS=0, STALL=0; ch1 all 0.
// - Miss: ch1 access high 4 cycles, resp on 4th.
//   -> ACC=1, MISS=1, STALL=3; next-cycle access&resp -> ACC=2, HIT=1.
// - Saturation: 260 hits on ch0.
//   -> HIT=255, ACC=255, sat_flag=2'b01; clr -> all 0, sat_flag=0.
// - Enable/clear: en=0 during a miss start, en=1 mid-WAIT.
//   -> MISS=0, STALL counts only the enabled cycles; clr coincident with a hit -> HIT=0.
// - Readout: rd_en with rd_ch=1, rd_sel=MISS in cycle N.
//   -> rd_valid=1 and the correct value in N+1; rd_ch=3 -> rd_data=0.
// - Reset: rst asserted in WAIT.
//   -> all counters and outputs 0, FSM in IDLE; the following access&resp counts as a hit.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types for the cache performance counter bank.
package perf_pkg;

    // Counter selector; the value doubles as the index into a channel's count vector.
    typedef enum logic [1:0] {
        SEL_ACC,
        SEL_HIT,
        SEL_MISS,
        SEL_STALL
    } perf_sel_t;

    typedef enum logic {
        CH_IDLE,
        CH_WAIT
    } perf_ch_state_t;

    localparam int unsigned NUM_SEL = 4;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control, monitored-channel and readout signals of the performance counter bank.
interface perf_counter_bank_if
    import perf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                en;
    logic                clr;
    logic [NUM_CH-1:0]   access;
    logic [NUM_CH-1:0]   resp;
    logic                rd_en;
    logic [CH_IDX_W-1:0] rd_ch;
    perf_sel_t           rd_sel;
    logic [CNT_W-1:0]    rd_data;
    logic                rd_valid;
    logic [NUM_CH-1:0]   sat_flag;

    modport master (
        output en, clr, access, resp, rd_en, rd_ch, rd_sel,
        input  rd_data, rd_valid, sat_flag
    );

    modport slave (
        input  en, clr, access, resp, rd_en, rd_ch, rd_sel,
        output rd_data, rd_valid, sat_flag
    );
endinterface

// File: rtl/perf_channel.sv
// One monitored channel: transaction FSM, four saturating counters and a sticky sat bit.
module perf_channel
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            clr,
    input  logic                            access,
    input  logic                            resp,
    output logic [NUM_SEL-1:0][CNT_W-1:0]   cnt,
    output logic                            sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

    perf_ch_state_t                 state_q, state_d;
    logic [NUM_SEL-1:0]             inc;
    logic [NUM_SEL-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                           sat_q, sat_d;

    // Classify each cycle; the FSM advances regardless of en so re-enabling never fakes a miss.
    always_comb begin
        state_d = state_q;
        inc     = '0;
        unique case (state_q)
            CH_IDLE: begin
                if (access) begin
                    inc[SEL_ACC] = 1'b1;
                    if (resp) begin
                        inc[SEL_HIT] = 1'b1;
                    end else begin
                        inc[SEL_MISS]  = 1'b1;
                        inc[SEL_STALL] = 1'b1;
                        state_d        = CH_WAIT;
                    end
                end
            end
            CH_WAIT: begin
                // Either the response completed it or access dropped (abort).
                if (access && !resp) begin
                    inc[SEL_STALL] = 1'b1;
                end else begin
                    state_d = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    // Saturating counter update; clr beats any same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (en) begin
            for (int i = 0; i < NUM_SEL; i++) begin
                if (inc[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                    if (cnt_q[i] == CNT_PRE) begin
                        sat_d = 1'b1;
                    end
                end
            end
        end
    end

    // State, counter and sat registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Per-channel cache performance monitor with a registered counter readout port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input logic                 clk,
    input logic                 rst,
    perf_counter_bank_if.slave  bus
);
    logic [NUM_SEL-1:0][CNT_W-1:0] ch_cnt [NUM_CH];
    logic [NUM_CH-1:0]             ch_sat;
    logic [CNT_W-1:0]              rd_mux;
    logic [CNT_W-1:0]              rd_data_q;
    logic                          rd_valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        perf_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (bus.en),
            .clr    (bus.clr),
            .access (bus.access[g]),
            .resp   (bus.resp[g]),
            .cnt    (ch_cnt[g]),
            .sat    (ch_sat[g])
        );
    end

    // Select the pre-increment count; channel indices past NUM_CH read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_ch == $bits(bus.rd_ch)'(i)) begin
                rd_mux = ch_cnt[i][bus.rd_sel];
            end
        end
    end

    // Readout register: data holds between strobes, valid is a one-cycle echo of rd_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.sat_flag = ch_sat;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_perf_counter_bank;
    import perf_pkg::*;

    localparam int NCH  = 2;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    perf_counter_bank_if #(.NUM_CH(NCH), .CNT_W(8)) bus ();
    perf_counter_bank_if #(.NUM_CH(3), .CNT_W(8))   bus3 ();

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Three-channel instance so an out-of-range rd_ch is expressible.
    perf_counter_bank #(.NUM_CH(3), .CNT_W(8)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel counts indexed by selector, plus "transaction outstanding".
    int m_cnt [NCH][4];
    bit m_busy [NCH];
    bit m_sat [NCH];
    int m_rd_data;
    bit m_rd_valid;
    bit m_init = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_cnt[c, k]) m_cnt[c][k] = 0;
            foreach (m_busy[c]) begin
                m_busy[c] = 1'b0;
                m_sat[c]  = 1'b0;
            end
            m_rd_data  = 0;
            m_rd_valid = 1'b0;
            m_init     = 1'b1;
        end else begin
            m_rd_valid = bus.rd_en;
            if (bus.rd_en) m_rd_data = m_cnt[int'(bus.rd_ch)][int'(bus.rd_sel)];
            for (int c = 0; c < NCH; c++) begin
                bit a, r, start;
                bit ev [4];
                a     = bus.access[c];
                r     = bus.resp[c];
                start = a && !m_busy[c];
                ev[0] = start;
                ev[1] = start && r;
                ev[2] = start && !r;
                ev[3] = a && !r;
                m_busy[c] = a && !r;
                if (bus.clr) begin
                    for (int k = 0; k < 4; k++) m_cnt[c][k] = 0;
                    m_sat[c] = 1'b0;
                end else if (bus.en) begin
                    for (int k = 0; k < 4; k++) begin
                        if (ev[k] && m_cnt[c][k] < MAXV) begin
                            m_cnt[c][k]++;
                            if (m_cnt[c][k] == MAXV) m_sat[c] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("rd_valid", int'(bus.rd_valid), int'(m_rd_valid));
            chk("rd_data", int'(bus.rd_data), m_rd_data);
            chk("sat_flag", int'(bus.sat_flag), int'({m_sat[1], m_sat[0]}));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.access = '0;
        bus.resp   = '0;
        bus.clr    = 1'b0;
        bus.rd_en  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int ch, input perf_sel_t sel, input int exp);
        bus.rd_en  = 1'b1;
        bus.rd_ch  = 1'(ch);
        bus.rd_sel = sel;
        cyc();
        bus.rd_en = 1'b0;
        chk(name, int'(bus.rd_data), exp);
        chk({name, "_valid"}, int'(bus.rd_valid), 1);
    endtask

    task automatic rd3_chk(input string name, input int ch, input perf_sel_t sel, input int exp);
        bus3.rd_en  = 1'b1;
        bus3.rd_ch  = 2'(ch);
        bus3.rd_sel = sel;
        cyc();
        bus3.rd_en = 1'b0;
        chk(name, int'(bus3.rd_data), exp);
        chk({name, "_valid"}, int'(bus3.rd_valid), 1);
    endtask

    initial begin
        bus.en = 1'b1;
        bus.rd_ch = '0;
        bus.rd_sel = SEL_ACC;
        idle();
        bus3.en = 1'b1;
        bus3.clr = 1'b0;
        bus3.access = '0;
        bus3.resp = '0;
        bus3.rd_en = 1'b0;
        bus3.rd_ch = '0;
        bus3.rd_sel = SEL_ACC;

        // Reset state
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("reset_rd_valid", int'(bus.rd_valid), 0);
        chk("reset_rd_data", int'(bus.rd_data), 0);
        chk("reset_sat", int'(bus.sat_flag), 0);
        rd_chk("reset_acc0", 0, SEL_ACC, 0);

        // Out-of-range channel on the three-channel instance
        bus3.access = 3'b100;
        bus3.resp   = 3'b100;
        cyc();
        bus3.access = '0;
        bus3.resp   = '0;
        rd3_chk("oor_ch3", 3, SEL_ACC, 0);
        rd3_chk("ch2_acc", 2, SEL_ACC, 1);

        // Three single-cycle hits on ch0
        bus.access = 2'b01;
        bus.resp   = 2'b01;
        cyc(3);
        idle();
        rd_chk("hit_acc0", 0, SEL_ACC, 3);
        rd_chk("hit_hit0", 0, SEL_HIT, 3);
        rd_chk("hit_miss0", 0, SEL_MISS, 0);
        rd_chk("hit_stall0", 0, SEL_STALL, 0);
        rd_chk("hit_acc1", 1, SEL_ACC, 0);

        // Miss on ch1: four access cycles, resp on the fourth, then a hit read in the same cycle
        bus.access = 2'b10;
        cyc(3);
        bus.resp = 2'b10;
        cyc();
        bus.rd_en  = 1'b1;
        bus.rd_ch  = 1'b1;
        bus.rd_sel = SEL_ACC;
        cyc();
        idle();
        chk("pre_inc_acc1", int'(bus.rd_data), 1);
        rd_chk("miss_acc1", 1, SEL_ACC, 2);
        rd_chk("miss_hit1", 1, SEL_HIT, 1);
        rd_chk("miss_miss1", 1, SEL_MISS, 1);
        rd_chk("miss_stall1", 1, SEL_STALL, 3);

        // Miss begins with en=0, re-enabled mid-wait
        bus.clr = 1'b1;
        cyc();
        bus.clr    = 1'b0;
        bus.en     = 1'b0;
        bus.access = 2'b01;
        cyc();
        bus.en = 1'b1;
        cyc(2);
        bus.resp = 2'b01;
        cyc();
        idle();
        rd_chk("en_acc0", 0, SEL_ACC, 0);
        rd_chk("en_miss0", 0, SEL_MISS, 0);
        rd_chk("en_stall0", 0, SEL_STALL, 2);
        bus.access = 2'b01;
        bus.resp   = 2'b01;
        bus.clr    = 1'b1;
        cyc();
        idle();
        rd_chk("clr_hit0", 0, SEL_HIT, 0);
        rd_chk("clr_stall0", 0, SEL_STALL, 0);

        // Saturation: 260 hits on ch0
        bus.access = 2'b01;
        bus.resp   = 2'b01;
        cyc(260);
        idle();
        chk("sat_set", int'(bus.sat_flag), 1);
        rd_chk("sat_hit0", 0, SEL_HIT, 255);
        rd_chk("sat_acc0", 0, SEL_ACC, 255);
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        chk("sat_clr", int'(bus.sat_flag), 0);
        rd_chk("sat_clr_hit0", 0, SEL_HIT, 0);

        // Reset while ch1 is waiting
        bus.access = 2'b10;
        cyc(2);
        bus.access = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_rd_data", int'(bus.rd_data), 0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        bus.access = 2'b10;
        bus.resp   = 2'b10;
        cyc();
        idle();
        rd_chk("rst_acc1", 1, SEL_ACC, 1);
        rd_chk("rst_hit1", 1, SEL_HIT, 1);
        rd_chk("rst_miss1", 1, SEL_MISS, 0);
        rd_chk("rst_stall1", 1, SEL_STALL, 0);

        // Random traffic, checked by the per-cycle compare process
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(999) == 0);
            bus.en     = ($urandom_range(9) != 0);
            bus.clr    = ($urandom_range(499) == 0);
            bus.access = 2'($urandom) | 2'($urandom);
            bus.resp   = 2'($urandom) & 2'($urandom);
            bus.rd_en  = 1'($urandom);
            bus.rd_ch  = 1'($urandom);
            bus.rd_sel = perf_sel_t'(2'($urandom));
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
